// File: rtl/cpu_pkg.sv
// Shared opcode/funct encodings, ALU operation enum and immediate extender.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_LUI
    } alu_op_e;

    // Widen a 16-bit immediate: zero-extend for logical ops, sign-extend otherwise.
    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic zext);
        return zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/Instr_Memory.sv
// 32-word instruction store with a combinational read port. The array is
// not reset so preloaded programs survive reset; the write port is tied off
// at the top and exists so the array has a defined synthesizable driver.
module Instr_Memory (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] Instr_Mem [0:31];

    // Optional word write (loader hook).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            Instr_Mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = Instr_Mem[rd_addr];

endmodule

// File: rtl/Reg_File.sv
// 32 x 32-bit register file: two combinational reads, one clocked write.
// Register 0 is hard-wired to zero on read and never written.
module Reg_File (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] Reg_File [0:31];

    // Asynchronous clear of every register; writes to $0 are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                Reg_File[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            Reg_File[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == 5'd0) ? 32'd0 : Reg_File[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'd0 : Reg_File[rt_addr];

endmodule

// File: rtl/alu.sv
// 32-bit two's-complement ALU; zero flag drives branch resolution.
module alu
    import cpu_pkg::*;
(
    input  logic signed [31:0] a,
    input  logic signed [31:0] b,
    input  alu_op_e            op,
    output logic        [31:0] y,
    output logic               zero
);

    // Operation select; arithmetic wraps silently.
    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = (a < b) ? 32'd1 : 32'd0;
            ALU_LUI: y = {b[15:0], 16'h0000};
            default: y = 32'd0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/decoder.sv
// Combinational main decoder: opcode/funct to datapath control.
module decoder
    import cpu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       zext,
    output logic       branch,
    output logic       branch_ne,
    output alu_op_e    alu_op
);

    // Defaults describe a NOP; each recognised opcode enables what it needs.
    always_comb begin
        reg_write = 1'b0;
        reg_dst   = 1'b0;
        alu_src   = 1'b0;
        zext      = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        alu_op    = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OP_SLTI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALU_SLT;
            end
            OP_ORI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                zext      = 1'b1;
                alu_op    = ALU_OR;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALU_LUI;
            end
            OP_BEQ: begin
                branch = 1'b1;
                alu_op = ALU_SUB;
            end
            OP_BNE: begin
                branch    = 1'b1;
                branch_ne = 1'b1;
                alu_op    = ALU_SUB;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/simple_single_cpu.sv
// Single-cycle MIPS-subset core: PC, next-PC logic and immediate extension,
// wired around the instruction memory, register file, decoder and ALU.
module simple_single_cpu
    import cpu_pkg::*;
(
    input logic clk_i,
    input logic rst_i
);

    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] next_pc;
    logic [31:0] ext_imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_y;
    logic signed [31:0] alu_a;
    logic signed [31:0] alu_b;
    logic        alu_zero;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic        zext;
    logic        branch;
    logic        branch_ne;
    logic        taken;
    alu_op_e     alu_op;
    logic [4:0]  wr_addr;
    logic        unused_bits;

    Instr_Memory IM (
        .clk     (clk_i),
        .wr_en   (1'b0),
        .wr_addr (5'd0),
        .wr_data (32'd0),
        .rd_addr (pc[6:2]),
        .rd_data (instr)
    );

    decoder u_decoder (
        .op        (instr[31:26]),
        .funct     (instr[5:0]),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .alu_src   (alu_src),
        .zext      (zext),
        .branch    (branch),
        .branch_ne (branch_ne),
        .alu_op    (alu_op)
    );

    assign wr_addr = reg_dst ? instr[15:11] : instr[20:16];

    Reg_File RF (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .rs_addr (instr[25:21]),
        .rt_addr (instr[20:16]),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_en   (reg_write),
        .wr_addr (wr_addr),
        .wr_data (alu_y)
    );

    assign ext_imm = extend_imm(instr[15:0], zext);
    assign alu_a   = rs_data;
    assign alu_b   = alu_src ? ext_imm : rt_data;

    alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // Branches compare via rs - rt; BNE inverts the sense of the zero flag.
    assign taken     = branch & (branch_ne ? ~alu_zero : alu_zero);
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {ext_imm[29:0], 2'b00};
    assign next_pc   = taken ? br_target : pc_plus4;

    // Shamt and the discarded next-PC bits are intentionally ignored.
    assign unused_bits = ^{next_pc[31:7], next_pc[1:0], instr[10:6]};

    // Program counter: word aligned, wraps within the 128-byte program space.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc <= '0;
        end else begin
            pc <= {25'd0, next_pc[6:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_simple_single_cpu.sv
// Bench for simple_single_cpu: preloads programs, runs them, and compares
// register contents against a table of hand-derived results.
module tb_simple_single_cpu;
    import cpu_pkg::*;

    logic clk;
    logic rst_i;

    simple_single_cpu dut (
        .clk_i (clk),
        .rst_i (rst_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          prog;
        string       name;
        int          rnum;
        logic [31:0] val;
    } vec_t;

    vec_t        tab[$];
    vec_t        sb[$];
    logic [31:0] progs [0:3][0:31];
    int          checks;
    int          failures;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic add_vec(input int p, input string n, input int r, input logic [31:0] v);
        vec_t e;
        e.prog = p;
        e.name = n;
        e.rnum = r;
        e.val  = v;
        tab.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic push_expected(input int p);
        foreach (tab[i]) begin
            if (tab[i].prog == p) sb.push_back(tab[i]);
        end
    endtask

    task automatic drain();
        vec_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, dut.RF.Reg_File[e.rnum], e.val);
        end
    endtask

    // Assert reset, load program p, verify cleared state, release, run.
    task automatic run_prog(input int p, input int cycles);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) dut.IM.Instr_Mem[i] = progs[p][i];
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("p%0d_rst_pc", p), dut.pc, 32'd0);
        for (int r = 0; r < 32; r++) begin
            check($sformatf("p%0d_rst_r%0d", p, r), dut.RF.Reg_File[r], 32'd0);
        end
        @(negedge clk);
        rst_i = 1'b1;
        push_expected(p);
        repeat (cycles) @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_i    = 1'b1;

        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 32; i++) progs[p][i] = 32'd0;

        // Program 0: arithmetic and signed compares
        progs[0][0] = enc_i(OP_ADDI, 0, 1, 10);
        progs[0][1] = enc_i(OP_ADDI, 0, 2, -3);
        progs[0][2] = enc_r(1, 2, 3, FN_ADD);
        progs[0][3] = enc_r(1, 2, 4, FN_SUB);
        progs[0][4] = enc_r(2, 1, 5, FN_SLT);
        progs[0][5] = enc_i(OP_SLTI, 1, 6, 5);
        progs[0][6] = enc_r(1, 2, 11, FN_SLT);
        progs[0][7] = enc_i(OP_SLTI, 2, 18, -1);
        add_vec(0, "a_r1",  1,  32'd10);
        add_vec(0, "a_r2",  2,  32'hFFFF_FFFD);
        add_vec(0, "a_r3",  3,  32'd7);
        add_vec(0, "a_r4",  4,  32'd13);
        add_vec(0, "a_r5",  5,  32'd1);
        add_vec(0, "a_r6",  6,  32'd0);
        add_vec(0, "a_r11", 11, 32'd0);
        add_vec(0, "a_r18", 18, 32'd1);

        // Program 1: logic, upper immediate, extension and wrap-around
        progs[1][0]  = enc_i(OP_ADDI, 0, 1, 10);
        progs[1][1]  = enc_i(OP_ADDI, 0, 2, -3);
        progs[1][2]  = enc_i(OP_LUI, 0, 7, 16'h1234);
        progs[1][3]  = enc_i(OP_ORI, 7, 7, 16'h5678);
        progs[1][4]  = enc_r(7, 1, 8, FN_AND);
        progs[1][5]  = enc_r(1, 2, 9, FN_OR);
        progs[1][6]  = enc_i(OP_ORI, 0, 12, 16'h8000);
        progs[1][7]  = enc_i(OP_ADDI, 0, 13, 16'h8000);
        progs[1][8]  = enc_r(2, 1, 19, FN_SUB);
        progs[1][9]  = enc_i(OP_LUI, 0, 21, 16'h8000);
        progs[1][10] = enc_i(OP_ADDI, 21, 22, -1);
        add_vec(1, "b_r1",  1,  32'd10);
        add_vec(1, "b_r2",  2,  32'hFFFF_FFFD);
        add_vec(1, "b_r7",  7,  32'h1234_5678);
        add_vec(1, "b_r8",  8,  32'h0000_0008);
        add_vec(1, "b_r9",  9,  32'hFFFF_FFFF);
        add_vec(1, "b_r12", 12, 32'h0000_8000);
        add_vec(1, "b_r13", 13, 32'hFFFF_8000);
        add_vec(1, "b_r19", 19, 32'hFFFF_FFF3);
        add_vec(1, "b_r21", 21, 32'h8000_0000);
        add_vec(1, "b_r22", 22, 32'h7FFF_FFFF);

        // Program 2: counted loop with BNE, then BEQ self-loop at 0x10
        progs[2][0] = enc_i(OP_ADDI, 0, 1, 3);
        progs[2][1] = enc_i(OP_ADDI, 2, 2, 1);
        progs[2][2] = enc_i(OP_ADDI, 1, 1, -1);
        progs[2][3] = enc_i(OP_BNE, 1, 0, -3);
        progs[2][4] = enc_i(OP_BEQ, 0, 0, -1);
        add_vec(2, "c_r1", 1, 32'd0);
        add_vec(2, "c_r2", 2, 32'd3);

        // Program 3: $0 protection, BEQ not taken, unknown op/funct are NOPs
        progs[3][0] = enc_i(OP_ADDI, 0, 0, 5);
        progs[3][1] = enc_r(0, 0, 10, FN_ADD);
        progs[3][2] = enc_i(OP_ADDI, 0, 1, 1);
        progs[3][3] = enc_i(OP_BEQ, 1, 0, 1);
        progs[3][4] = enc_i(OP_ADDI, 0, 14, 7);
        progs[3][5] = enc_i(OP_ADDI, 0, 15, 9);
        progs[3][6] = enc_i(6'h3F, 0, 16, 5);
        progs[3][7] = enc_r(1, 1, 17, 6'h27);
        progs[3][8] = enc_i(OP_BEQ, 0, 0, -1);
        add_vec(3, "d_r0",  0,  32'd0);
        add_vec(3, "d_r10", 10, 32'd0);
        add_vec(3, "d_r1",  1,  32'd1);
        add_vec(3, "d_r14", 14, 32'd7);
        add_vec(3, "d_r15", 15, 32'd9);
        add_vec(3, "d_r16", 16, 32'd0);
        add_vec(3, "d_r17", 17, 32'd0);

        run_prog(0, 10);
        run_prog(1, 14);

        run_prog(2, 100);
        check("c_pc_loop", dut.pc, 32'h0000_0010);
        @(posedge clk);
        #1;
        check("c_pc_hold", dut.pc, 32'h0000_0010);
        check("c_r2_hold", dut.RF.Reg_File[2], 32'd3);

        run_prog(3, 20);
        check("d_pc_loop", dut.pc, 32'h0000_0020);

        // Mid-program reset: partial run, async clear, rerun from address 0
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) dut.IM.Instr_Mem[i] = progs[0][i];
        @(negedge clk);
        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_pre_r3", dut.RF.Reg_File[3], 32'd7);
        check("mid_pre_pc", dut.pc, 32'h0000_000C);
        rst_i = 1'b0;
        #1;
        check("mid_rst_pc", dut.pc, 32'd0);
        check("mid_rst_r1", dut.RF.Reg_File[1], 32'd0);
        check("mid_rst_r2", dut.RF.Reg_File[2], 32'd0);
        check("mid_rst_r3", dut.RF.Reg_File[3], 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        push_expected(0);
        repeat (10) @(posedge clk);
        #1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
